// File: rtl/pipe_stage_latch_pkg.sv
// Shared codes and default widths for the inter-stage pipeline register.
package pipe_stage_latch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int STAT_W_DEF = 2;

    // Status reported downstream and back to the hazard controller.
    typedef enum logic [1:0] {
        LS_EMPTY = 2'd0,
        LS_VALID = 2'd1,
        LS_HELD  = 2'd2,
        LS_ERR   = 2'd3
    } layer_status_e;

    // Stall codes from the hazard controller; code 1 behaves like GO.
    typedef enum logic [1:0] {
        SC_GO     = 2'd0,
        SC_GO_ALT = 2'd1,
        SC_STALL  = 2'd2,
        SC_FLUSH  = 2'd3
    } stall_code_e;

    // Resolved per-cycle action after applying the priority order.
    typedef enum logic [1:0] {
        ACT_GO,
        ACT_STALL,
        ACT_CLEAR,
        ACT_FLUSH
    } stage_action_e;

    // Flush beats clear, clear beats stall, anything else advances.
    function automatic stage_action_e decode_action(input logic [1:0] code,
                                                    input logic       clr);
        stage_action_e act;
        if (code == SC_FLUSH) begin
            act = ACT_FLUSH;
        end else if (clr) begin
            act = ACT_CLEAR;
        end else if (code == SC_STALL) begin
            act = ACT_STALL;
        end else begin
            act = ACT_GO;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_latch_pipe_entry.sv
// One pipeline entry: valid bit plus npc/inst/rd/rs1/rs2 payload.
// zero clears everything, kill clears only the valid bit, load captures d_*.
module pipe_entry #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en,
    input  logic              load,
    input  logic              kill,
    input  logic              zero,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_npc,
    input  logic [INST_W-1:0] d_inst,
    input  logic [REG_W-1:0]  d_rd,
    input  logic [REG_W-1:0]  d_rs1,
    input  logic [REG_W-1:0]  d_rs2,
    output logic              q_valid,
    output logic [ADDR_W-1:0] q_npc,
    output logic [INST_W-1:0] q_inst,
    output logic [REG_W-1:0]  q_rd,
    output logic [REG_W-1:0]  q_rs1,
    output logic [REG_W-1:0]  q_rs2
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] npc_q,   npc_d;
    logic [INST_W-1:0] inst_q,  inst_d;
    logic [REG_W-1:0]  rd_q,    rd_d;
    logic [REG_W-1:0]  rs1_q,   rs1_d;
    logic [REG_W-1:0]  rs2_q,   rs2_d;

    // Next-state selection: zero > kill > load > hold; en=0 holds everything.
    always_comb begin
        valid_d = valid_q;
        npc_d   = npc_q;
        inst_d  = inst_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (en) begin
            if (zero) begin
                valid_d = 1'b0;
                npc_d   = '0;
                inst_d  = '0;
                rd_d    = '0;
                rs1_d   = '0;
                rs2_d   = '0;
            end else if (kill) begin
                valid_d = 1'b0;
            end else if (load) begin
                valid_d = d_valid;
                npc_d   = d_npc;
                inst_d  = d_inst;
                rd_d    = d_rd;
                rs1_d   = d_rs1;
                rs2_d   = d_rs2;
            end
        end
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            npc_q   <= '0;
            inst_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            npc_q   <= npc_d;
            inst_q  <= inst_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    assign q_valid = valid_q;
    assign q_npc   = npc_q;
    assign q_inst  = inst_q;
    assign q_rd    = rd_q;
    assign q_rs1   = rs1_q;
    assign q_rs2   = rs2_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register: one output entry plus a one-entry skid
// buffer, driven by the hazard controller's stall code and clear pulse.
// The status codes are 2 bits wide; STAT_W is expected to stay at 2.
module pipe_stage_latch
    import pipe_stage_latch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [STAT_W-1:0] stall_code,
    input  logic              ans_clear,
    input  logic [STAT_W-1:0] up_status,
    input  logic [ADDR_W-1:0] up_npc,
    input  logic [INST_W-1:0] up_inst,
    input  logic [REG_W-1:0]  up_rd,
    input  logic [REG_W-1:0]  up_rs1,
    input  logic [REG_W-1:0]  up_rs2,
    output logic              up_ready,
    output logic [STAT_W-1:0] dn_status,
    output logic [ADDR_W-1:0] dn_npc,
    output logic [INST_W-1:0] dn_inst,
    output logic [REG_W-1:0]  dn_rd,
    output logic [REG_W-1:0]  dn_rs1,
    output logic [REG_W-1:0]  dn_rs2,
    output logic [REG_W-1:0]  hz_rd,
    output logic [1:0]        occupancy
);

    layer_status_e status_q, status_d;
    stage_action_e act;
    logic          up_valid;

    logic              out_load, out_kill, out_zero, out_d_valid;
    logic [ADDR_W-1:0] out_d_npc;
    logic [INST_W-1:0] out_d_inst;
    logic [REG_W-1:0]  out_d_rd, out_d_rs1, out_d_rs2;
    logic              out_valid;

    logic              skid_load, skid_kill, skid_zero;
    logic              skid_valid;
    logic [ADDR_W-1:0] skid_npc;
    logic [INST_W-1:0] skid_inst;
    logic [REG_W-1:0]  skid_rd, skid_rs1, skid_rs2;

    assign up_valid = |up_status;
    assign act      = decode_action(stall_code[1:0], ans_clear);

    // Output entry takes the skid when it holds something, else upstream.
    always_comb begin
        out_d_valid = up_valid;
        out_d_npc   = up_npc;
        out_d_inst  = up_inst;
        out_d_rd    = up_rd;
        out_d_rs1   = up_rs1;
        out_d_rs2   = up_rs2;
        if (skid_valid) begin
            out_d_valid = 1'b1;
            out_d_npc   = skid_npc;
            out_d_inst  = skid_inst;
            out_d_rd    = skid_rd;
            out_d_rs1   = skid_rs1;
            out_d_rs2   = skid_rs2;
        end
    end

    // Entry controls and next downstream status for the resolved action.
    always_comb begin
        out_load  = 1'b0;
        out_kill  = 1'b0;
        out_zero  = 1'b0;
        skid_load = 1'b0;
        skid_kill = 1'b0;
        skid_zero = 1'b0;
        status_d  = status_q;
        if (rdy_in) begin
            unique case (act)
                ACT_FLUSH: begin
                    out_zero  = 1'b1;
                    skid_zero = 1'b1;
                    status_d  = LS_ERR;
                end
                ACT_CLEAR: begin
                    out_kill  = 1'b1;
                    skid_load = up_valid && !skid_valid;
                    status_d  = LS_EMPTY;
                end
                ACT_STALL: begin
                    skid_load = up_valid && !skid_valid;
                    status_d  = out_valid ? LS_HELD : LS_EMPTY;
                end
                ACT_GO: begin
                    out_load = 1'b1;
                    if (skid_valid) begin
                        skid_load = up_valid;
                        skid_kill = !up_valid;
                        status_d  = LS_VALID;
                    end else begin
                        status_d  = up_valid ? LS_VALID : LS_EMPTY;
                    end
                end
                default: status_d = status_q;
            endcase
        end
    end

    // Downstream status register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            status_q <= LS_EMPTY;
        end else begin
            status_q <= status_d;
        end
    end

    pipe_entry #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .REG_W  (REG_W)
    ) u_out (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en      (rdy_in),
        .load    (out_load),
        .kill    (out_kill),
        .zero    (out_zero),
        .d_valid (out_d_valid),
        .d_npc   (out_d_npc),
        .d_inst  (out_d_inst),
        .d_rd    (out_d_rd),
        .d_rs1   (out_d_rs1),
        .d_rs2   (out_d_rs2),
        .q_valid (out_valid),
        .q_npc   (dn_npc),
        .q_inst  (dn_inst),
        .q_rd    (dn_rd),
        .q_rs1   (dn_rs1),
        .q_rs2   (dn_rs2)
    );

    pipe_entry #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .REG_W  (REG_W)
    ) u_skid (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en      (rdy_in),
        .load    (skid_load),
        .kill    (skid_kill),
        .zero    (skid_zero),
        .d_valid (1'b1),
        .d_npc   (up_npc),
        .d_inst  (up_inst),
        .d_rd    (up_rd),
        .d_rs1   (up_rs1),
        .d_rs2   (up_rs2),
        .q_valid (skid_valid),
        .q_npc   (skid_npc),
        .q_inst  (skid_inst),
        .q_rd    (skid_rd),
        .q_rs1   (skid_rs1),
        .q_rs2   (skid_rs2)
    );

    assign up_ready  = ~skid_valid;
    assign dn_status = STAT_W'(status_q);
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};
    // Held entries keep exporting rd so the controller keeps seeing the hazard.
    assign hz_rd     = (status_q == LS_VALID || status_q == LS_HELD) ? dn_rd : '0;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_pipe_stage_latch;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ent_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, ans_clear;
    logic [1:0]  stall_code, up_status;
    logic [31:0] up_npc, up_inst;
    logic [4:0]  up_rd, up_rs1, up_rs2;
    logic        up_ready;
    logic [1:0]  dn_status, occupancy;
    logic [31:0] dn_npc, dn_inst;
    logic [4:0]  dn_rd, dn_rs1, dn_rs2, hz_rd;

    pipe_stage_latch dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .stall_code (stall_code),
        .ans_clear  (ans_clear),
        .up_status  (up_status),
        .up_npc     (up_npc),
        .up_inst    (up_inst),
        .up_rd      (up_rd),
        .up_rs1     (up_rs1),
        .up_rs2     (up_rs2),
        .up_ready   (up_ready),
        .dn_status  (dn_status),
        .dn_npc     (dn_npc),
        .dn_inst    (dn_inst),
        .dn_rd      (dn_rd),
        .dn_rs1     (dn_rs1),
        .dn_rs2     (dn_rs2),
        .hz_rd      (hz_rd),
        .occupancy  (occupancy)
    );

    always #5 clk_in = ~clk_in;

    // Reference: entries in FIFO order; head sits in the output slot when out_busy.
    ent_t fifo[$];
    bit   out_busy;
    int   m_status;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int skid_cnt();
        return fifo.size() - int'(out_busy);
    endfunction

    task automatic model_update(input logic rst, input logic rdy, input logic [1:0] code,
                                input logic clr, input logic up_v, input ent_t e);
        if (rst) begin
            fifo.delete();
            out_busy = 0;
            m_status = 0;
        end else if (rdy) begin
            if (code == 2'd3) begin
                fifo.delete();
                out_busy = 0;
                m_status = 3;
            end else if (clr) begin
                if (out_busy) void'(fifo.pop_front());
                out_busy = 0;
                if (fifo.size() == 0 && up_v) fifo.push_back(e);
                m_status = 0;
            end else if (code == 2'd2) begin
                if (skid_cnt() == 0 && up_v) fifo.push_back(e);
                m_status = out_busy ? 2 : 0;
            end else begin
                if (out_busy) void'(fifo.pop_front());
                if (fifo.size() > 0) begin
                    out_busy = 1;
                    if (up_v) fifo.push_back(e);
                end else if (up_v) begin
                    fifo.push_back(e);
                    out_busy = 1;
                end else begin
                    out_busy = 0;
                end
                m_status = out_busy ? 1 : 0;
            end
        end
    endtask

    task automatic check_all();
        logic [4:0] exp_hz;
        exp_hz = 5'd0;
        if ((m_status == 1 || m_status == 2) && out_busy) exp_hz = fifo[0].rd;
        check_eq("dn_status", 64'(dn_status), 64'(m_status));
        check_eq("occupancy", 64'(occupancy), 64'(fifo.size()));
        check_eq("up_ready",  64'(up_ready),  64'(skid_cnt() == 0));
        check_eq("hz_rd",     64'(hz_rd),     64'(exp_hz));
        if (out_busy) begin
            check_eq("dn_npc",  64'(dn_npc),  64'(fifo[0].npc));
            check_eq("dn_inst", 64'(dn_inst), 64'(fifo[0].inst));
            check_eq("dn_rd",   64'(dn_rd),   64'(fifo[0].rd));
            check_eq("dn_rs1",  64'(dn_rs1),  64'(fifo[0].rs1));
            check_eq("dn_rs2",  64'(dn_rs2),  64'(fifo[0].rs2));
        end
        if (m_status == 3) begin
            check_eq("flush_npc_zero",  64'(dn_npc),  64'd0);
            check_eq("flush_inst_zero", 64'(dn_inst), 64'd0);
        end
    endtask

    // One clock: drive inputs, advance the model, sample after the edge.
    task automatic step(input logic rst, input logic rdy, input logic [1:0] code,
                        input logic clr, input logic [1:0] ust,
                        input logic [31:0] npc, input logic [4:0] rd);
        ent_t e;
        e.npc  = npc;
        e.inst = $urandom;
        e.rd   = rd;
        e.rs1  = 5'($urandom_range(0, 31));
        e.rs2  = 5'($urandom_range(0, 31));
        rst_in     = rst;
        rdy_in     = rdy;
        stall_code = code;
        ans_clear  = clr;
        up_status  = ust;
        up_npc     = e.npc;
        up_inst    = e.inst;
        up_rd      = e.rd;
        up_rs1     = e.rs1;
        up_rs2     = e.rs2;
        model_update(rst, rdy, code, clr, ust != 2'd0, e);
        @(posedge clk_in);
        #1;
        check_all();
    endtask

    initial begin
        out_busy = 0;
        m_status = 0;

        // Reset
        step(1, 1, 0, 0, 0, 32'h0, 5'd0);
        check_eq("rst_dn_npc",  64'(dn_npc),  64'd0);
        check_eq("rst_dn_inst", 64'(dn_inst), 64'd0);
        check_eq("rst_dn_rd",   64'(dn_rd),   64'd0);
        check_eq("rst_up_ready", 64'(up_ready), 64'd1);

        // Pass-through
        step(0, 1, 0, 0, 1, 32'h104, 5'd5);
        check_eq("pass_npc", 64'(dn_npc), 64'h104);
        check_eq("pass_hz",  64'(hz_rd),  64'd5);
        step(0, 1, 0, 0, 0, 32'h0, 5'd0);
        check_eq("pass_empty", 64'(dn_status), 64'd0);

        // Stall with skid capture, then drain in order
        step(0, 1, 0, 0, 1, 32'h104, 5'd5);
        step(0, 1, 2, 0, 1, 32'h108, 5'd6);
        check_eq("stall_status", 64'(dn_status), 64'd2);
        check_eq("stall_npc",    64'(dn_npc),    64'h104);
        check_eq("stall_occ",    64'(occupancy), 64'd2);
        check_eq("stall_ready",  64'(up_ready),  64'd0);
        step(0, 1, 0, 0, 0, 32'h0, 5'd0);
        check_eq("drain_npc",   64'(dn_npc),   64'h108);
        check_eq("drain_ready", 64'(up_ready), 64'd1);

        // Flush with full stage; upstream in the flush cycle is dropped
        step(0, 1, 2, 0, 1, 32'h110, 5'd7);
        step(0, 1, 3, 0, 1, 32'h10c, 5'd8);
        check_eq("flush_status", 64'(dn_status), 64'd3);
        check_eq("flush_occ",    64'(occupancy), 64'd0);
        step(0, 1, 0, 0, 0, 32'h0, 5'd0);
        check_eq("after_flush_status", 64'(dn_status), 64'd0);
        check_eq("no_10c", 64'(dn_npc == 32'h10c), 64'd0);

        // Clear together with flush behaves as flush
        step(0, 1, 0, 0, 1, 32'h104, 5'd5);
        step(0, 1, 2, 0, 1, 32'h108, 5'd6);
        step(0, 1, 3, 1, 0, 32'h0, 5'd0);
        check_eq("clr_flush_status", 64'(dn_status), 64'd3);

        // Clear alone keeps the skid, which is promoted on the next advance
        step(0, 1, 0, 0, 1, 32'h104, 5'd5);
        step(0, 1, 2, 0, 1, 32'h108, 5'd6);
        step(0, 1, 0, 1, 0, 32'h0, 5'd0);
        check_eq("clr_status", 64'(dn_status), 64'd0);
        check_eq("clr_occ",    64'(occupancy), 64'd1);
        step(0, 1, 0, 0, 0, 32'h0, 5'd0);
        check_eq("clr_next_npc", 64'(dn_npc), 64'h108);

        // Freeze for three cycles mid-stall
        step(0, 1, 0, 0, 1, 32'h200, 5'd9);
        step(0, 1, 2, 0, 1, 32'h204, 5'd10);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2'(i), 1'(i == 1), 1, 32'h300 + 32'(i), 5'd11);
            check_eq("frz_npc", 64'(dn_npc), 64'h200);
            check_eq("frz_occ", 64'(occupancy), 64'd2);
        end
        step(0, 1, 0, 0, 0, 32'h0, 5'd0);
        check_eq("frz_release_npc", 64'(dn_npc), 64'h204);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic       r_rst, r_rdy, r_clr;
            logic [1:0] r_code, r_ust;
            int         sel;
            r_rst = ($urandom_range(0, 199) == 0);
            r_rdy = ($urandom_range(0, 9) != 0);
            sel   = $urandom_range(0, 9);
            r_code = (sel < 5) ? 2'd0 : (sel == 5) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            r_clr = ($urandom_range(0, 11) == 0);
            r_ust = 2'd0;
            if (skid_cnt() == 0 && $urandom_range(0, 2) != 0) r_ust = 2'($urandom_range(1, 3));
            step(r_rst, r_rdy, r_code, r_clr, r_ust, $urandom, 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
